audio_adc_rx: RTL and testbench
===============================

Name: audio_adc_rx

Overview:
- Capture side of the codec audio interface; the DAC path in sound_gen is the transmit side.
- Runs on the 12 MHz codec clock, which the codec uses as its bit clock in USB mode. Drives the ADC frame-sync pulse to the codec (DSP mode A).
- Deserialises MSB-first left/right ADC words from aud_adcdat and presents each stereo pair to downstream logic through a valid/ready handshake, with a sticky overrun flag.

Parameters:
- DATA_W, 16, bits per channel word.
- FRAME_LEN, 250, clk cycles per stereo frame (12 MHz / 250 = 48 kHz). Must satisfy FRAME_LEN >= DATA_OFFSET + 2*DATA_W + 1.
- DATA_OFFSET, 1, counter value at which the left MSB is sampled.

Ports:
- clk  in  1  12 MHz codec clock (same net as aud_clk12); sole clock.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  run capture; 0 = idle.
- aud_adclrck  out  1  ADC frame-sync pulse to codec.
- aud_adcdat  in  1  serial ADC data from codec, synchronous to clk.
- sample_left  out  DATA_W  captured left word (two's complement).
- sample_right  out  DATA_W  captured right word.
- sample_valid  out  1  stereo pair available.
- sample_ready  in  1  consumer accepts the pair when valid&ready.
- overrun  out  1  sticky: at least one frame dropped.
- clr_overrun  in  1  synchronous clear of overrun.

Behaviour:
- Reset:
  - Clock and reset: one clock; reset is asynchronous and active-high.
  - On reset: cnt=0, state=IDLE, aud_adclrck=0, sample_left=0, sample_right=0, sample_valid=0, overrun=0, shift registers=0.
- States:
  - IDLE: cnt held 0, aud_adclrck=0, no sampling. Moves to RUN on the first cycle enable=1.
  - RUN: cnt increments 0..FRAME_LEN-1 and wraps to 0. Returns to IDLE when enable=0.
- Frame timing (RUN):
  - aud_adclrck is registered; it is 1 exactly during cycles where cnt==0, else 0. The first pulse is the first RUN cycle.
  - aud_adcdat is sampled on the rising clk edge with no synchroniser.
  - Left: bits shifted in MSB-first at cnt = DATA_OFFSET .. DATA_OFFSET+DATA_W-1.
  - Right: bits shifted in MSB-first at cnt = DATA_OFFSET+DATA_W .. DATA_OFFSET+2*DATA_W-1.
  - aud_adcdat is ignored at all other counts.
- Frame completion: at the cycle after the last right bit (cnt = DATA_OFFSET+2*DATA_W), the frame is "complete".
  - If sample_valid=0 or sample_ready=1: load sample_left/right from the shift registers and set sample_valid=1.
  - Otherwise: drop the new pair, keep outputs stable, set overrun=1.
- Handshake:
  - sample_valid drops the cycle after valid&ready, unless a completion loads a new pair in that same cycle; then valid stays 1 with new data and overrun is not set.
  - sample_left/right must not change while valid=1 and ready=0.
- Latency: 1 clk from the last data bit to sample_valid=1.
- Overrun: set has priority over clr_overrun in the same cycle; otherwise clr_overrun clears it next edge.
- enable deasserted mid-frame: the partial frame is discarded, cnt goes to 0 and aud_adclrck to 0 next edge. A pending sample_valid pair is retained until consumed.
- enable reasserted: a new frame starts with a fresh sync pulse. Shift registers need no clearing, since every bit is rewritten.
- Reset mid-frame: immediate asynchronous return to the reset values; a pending sample is lost.

Decomposition:
- Shared package audio_pkg holds:
  - constants AUDIO_DATA_W=16 and AUDIO_FRAME_LEN=250, shared with sound_gen so TX and RX use identical frame geometry;
  - typedef audio_sample_t (logic signed [DATA_W-1:0]);
  - state enum {IDLE, RUN}.
- One sub-module, audio_frame_timer, owns the counter, state and sync pulse, and exports cnt and the sync signal. It is reusable by the DAC path.

Test Plan:
- Basic capture (DATA_W=16, DATA_OFFSET=1): after enable, drive left=0xA5C3 and right=0x1234 MSB-first at cnt 1..32 -> aud_adclrck=1 only at cnt 0; at cnt 33 sample_left=0xA5C3, sample_right=0x1234, sample_valid=1. With ready=1 next cycle, valid=0.
- Back-pressure/overrun: hold sample_ready=0 across two frames (second frame 0x7FFF/0x8000) -> outputs stay 0xA5C3/0x1234, overrun=1 at the second completion. clr_overrun pulse -> overrun=0.
- Simultaneous: ready=1 exactly at the completion cycle of frame 2 while valid=1 -> outputs become frame-2 data, valid stays 1, overrun stays 0.
- Enable drop: deassert enable at cnt=20 -> no valid for that frame, aud_adclrck=0 thereafter. Re-enable -> sync pulse on the first cycle and a correct capture of 0x00FF/0xFF00.
- Wrap: run 3 consecutive frames -> sync pulses exactly 250 cycles apart and three valid pulses at cnt 33.
- Reset at cnt=10 with valid pending -> all outputs 0 immediately; after release with enable=1, the first sync pulse is on the first clocked cycle.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared audio-interface definitions used by both the ADC capture path and
// the DAC transmit path, so both sides agree on frame geometry.
package audio_pkg;

    localparam int AUDIO_DATA_W      = 16;
    localparam int AUDIO_FRAME_LEN   = 250;
    localparam int AUDIO_DATA_OFFSET = 1;

    typedef logic signed [AUDIO_DATA_W-1:0] audio_sample_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } audio_state_t;

    // Counter width needed to hold 0..frame_len-1 (at least one bit).
    function automatic int audio_cnt_w(input int frame_len);
        return (frame_len > 1) ? $clog2(frame_len) : 1;
    endfunction

endpackage

// File: rtl/audio_frame_timer.sv
// Frame timer: owns the IDLE/RUN state, the position counter inside a stereo
// frame and the one-cycle frame-sync pulse at position 0.
module audio_frame_timer
    import audio_pkg::*;
#(
    parameter int FRAME_LEN = AUDIO_FRAME_LEN,
    parameter int CNT_W     = audio_cnt_w(FRAME_LEN)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    output logic [CNT_W-1:0] cnt,
    output logic             sync,
    output logic             running
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    audio_state_t     state_r;
    logic [CNT_W-1:0] cnt_r;
    logic             sync_r;

    // State machine: count positions while enabled, pulse sync whenever the
    // next position is 0 so the pulse lines up exactly with cnt == 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
            cnt_r   <= CNT_ZERO;
            sync_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    cnt_r <= CNT_ZERO;
                    if (enable) begin
                        state_r <= RUN;
                        sync_r  <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                        sync_r  <= 1'b0;
                    end
                end
                RUN: begin
                    if (!enable) begin
                        state_r <= IDLE;
                        cnt_r   <= CNT_ZERO;
                        sync_r  <= 1'b0;
                    end else if (cnt_r == CNT_LAST) begin
                        cnt_r  <= CNT_ZERO;
                        sync_r <= 1'b1;
                    end else begin
                        cnt_r  <= cnt_r + CNT_ONE;
                        sync_r <= 1'b0;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    cnt_r   <= CNT_ZERO;
                    sync_r  <= 1'b0;
                end
            endcase
        end
    end

    assign cnt     = cnt_r;
    assign sync    = sync_r;
    assign running = (state_r == RUN);

endmodule

// File: rtl/audio_adc_rx.sv
// Codec ADC capture: drives the DSP-mode frame sync, deserialises the
// MSB-first left/right words and hands each stereo pair downstream through a
// valid/ready handshake with a sticky overrun flag.
module audio_adc_rx
    import audio_pkg::*;
#(
    parameter int DATA_W      = AUDIO_DATA_W,
    parameter int FRAME_LEN   = AUDIO_FRAME_LEN,
    parameter int DATA_OFFSET = AUDIO_DATA_OFFSET
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    output logic              aud_adclrck,
    input  logic              aud_adcdat,
    output logic [DATA_W-1:0] sample_left,
    output logic [DATA_W-1:0] sample_right,
    output logic              sample_valid,
    input  logic              sample_ready,
    output logic              overrun,
    input  logic              clr_overrun
);

    localparam int CNT_W = audio_cnt_w(FRAME_LEN);

    // Window boundaries inside the frame; R_END is exclusive.
    localparam logic [CNT_W-1:0] L_FIRST  = CNT_W'(DATA_OFFSET);
    localparam logic [CNT_W-1:0] R_FIRST  = CNT_W'(DATA_OFFSET + DATA_W);
    localparam logic [CNT_W-1:0] R_END    = CNT_W'(DATA_OFFSET + 2 * DATA_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_OFFSET + 2 * DATA_W - 1);

    logic [CNT_W-1:0]  cnt_s;
    logic              sync_s;
    logic              running_s;

    logic              shift_left_s;
    logic              shift_right_s;
    logic              complete_s;
    logic              take_s;
    logic              drop_s;
    logic [DATA_W-1:0] right_next_s;

    logic [DATA_W-1:0] left_sh_r;
    logic [DATA_W-1:0] right_sh_r;
    logic [DATA_W-1:0] left_r;
    logic [DATA_W-1:0] right_r;
    logic              valid_r;
    logic              ovr_r;

    audio_frame_timer #(
        .FRAME_LEN (FRAME_LEN),
        .CNT_W     (CNT_W)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .enable  (enable),
        .cnt     (cnt_s),
        .sync    (sync_s),
        .running (running_s)
    );

    // Decode which bit window the current position falls in and whether the
    // frame completes on this edge (the edge that samples the last right bit,
    // so the pair is visible one cycle after that bit).
    always_comb begin
        shift_left_s  = 1'b0;
        shift_right_s = 1'b0;
        complete_s    = 1'b0;
        if (running_s) begin
            shift_left_s  = (cnt_s >= L_FIRST) && (cnt_s < R_FIRST);
            shift_right_s = (cnt_s >= R_FIRST) && (cnt_s < R_END);
            complete_s    = enable && (cnt_s == LAST_BIT);
        end else begin
            shift_left_s  = 1'b0;
            shift_right_s = 1'b0;
            complete_s    = 1'b0;
        end
        right_next_s = {right_sh_r[DATA_W-2:0], aud_adcdat};
        take_s       = complete_s && (!valid_r || sample_ready);
        drop_s       = complete_s && valid_r && !sample_ready;
    end

    // Deserialisers: shift the raw codec bit in MSB-first during each window.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            left_sh_r  <= {DATA_W{1'b0}};
            right_sh_r <= {DATA_W{1'b0}};
        end else begin
            if (shift_left_s) begin
                left_sh_r <= {left_sh_r[DATA_W-2:0], aud_adcdat};
            end
            if (shift_right_s) begin
                right_sh_r <= right_next_s;
            end
        end
    end

    // Output stage: load a finished pair when the slot is free or being
    // consumed this cycle, otherwise drop it and flag the overrun.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            left_r  <= {DATA_W{1'b0}};
            right_r <= {DATA_W{1'b0}};
            valid_r <= 1'b0;
            ovr_r   <= 1'b0;
        end else begin
            if (take_s) begin
                left_r  <= left_sh_r;
                right_r <= right_next_s;
                valid_r <= 1'b1;
            end else if (valid_r && sample_ready) begin
                valid_r <= 1'b0;
            end
            if (drop_s) begin
                ovr_r <= 1'b1;
            end else if (clr_overrun) begin
                ovr_r <= 1'b0;
            end
        end
    end

    assign aud_adclrck  = sync_s;
    assign sample_left  = left_r;
    assign sample_right = right_r;
    assign sample_valid = valid_r;
    assign overrun      = ovr_r;

endmodule

// File: tb/tb_audio_adc_rx.sv
// Bench for audio_adc_rx: a frame-level reference model tracks position in
// the frame, the words being transmitted and the one-slot output buffer,
// with table-driven frame scenarios, hand-written corner sequences and a
// randomized phase.
module tb_audio_adc_rx;

    localparam int W   = 16;
    localparam int FL  = 250;
    localparam int OFF = 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic          aud_adclrck;
    logic          aud_adcdat;
    logic [W-1:0]  sample_left;
    logic [W-1:0]  sample_right;
    logic          sample_valid;
    logic          sample_ready;
    logic          overrun;
    logic          clr_overrun;

    always #5 clk = ~clk;

    audio_adc_rx #(
        .DATA_W      (W),
        .FRAME_LEN   (FL),
        .DATA_OFFSET (OFF)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .aud_adclrck  (aud_adclrck),
        .aud_adcdat   (aud_adcdat),
        .sample_left  (sample_left),
        .sample_right (sample_right),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .overrun      (overrun),
        .clr_overrun  (clr_overrun)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: running flag, position in frame, words on the wire,
    // and the consumer-facing slot.
    bit           m_run;
    int           m_pos;
    logic [W-1:0] m_lw, m_rw, nl, nr;
    bit           m_valid, m_ovr;
    logic [W-1:0] m_l, m_r;

    int cyc        = 0;
    int last_sync  = -1;
    bit track_sync = 1'b0;

    logic         s_v33, s_o33, s_v34, s_o101;
    logic [W-1:0] s_l33, s_r33;

    typedef struct {
        logic [W-1:0] lw, rw;
        int           mode;      // 0: ready low, 1: ready high, 2: ready only at last bit
        int           clr_pos;
        logic         v33;
        logic [W-1:0] l33, r33;
        logic         o33, v34, o101;
    } vec_t;

    vec_t tbl [5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_run = 1'b0; m_pos = 0; m_valid = 1'b0; m_ovr = 1'b0;
        m_l = '0; m_r = '0; m_lw = '0; m_rw = '0;
    endtask

    // One clock: drive the serial bit, advance the model, compare at negedge.
    task automatic tick();
        logic bit_v;
        bit complete, keep;
        if (m_run && m_pos == 0) begin
            m_lw = nl;
            m_rw = nr;
        end
        bit_v = 1'($urandom);
        if (m_run && m_pos >= OFF && m_pos < OFF + W)
            bit_v = m_lw[W-1-(m_pos-OFF)];
        else if (m_run && m_pos >= OFF + W && m_pos < OFF + 2*W)
            bit_v = m_rw[W-1-(m_pos-OFF-W)];
        aud_adcdat = bit_v;

        complete = m_run && enable && (m_pos == OFF + 2*W - 1);
        keep     = m_valid && !sample_ready;
        if (complete) begin
            if (!keep) begin
                m_valid = 1'b1; m_l = m_lw; m_r = m_rw;
            end else begin
                m_ovr = 1'b1;
            end
        end else if (m_valid && sample_ready) begin
            m_valid = 1'b0;
        end
        if (clr_overrun && !(complete && keep)) m_ovr = 1'b0;

        if (!m_run) begin
            if (enable) begin m_run = 1'b1; m_pos = 0; end
        end else if (enable) begin
            m_pos = (m_pos + 1) % FL;
        end else begin
            m_run = 1'b0; m_pos = 0;
        end

        @(posedge clk);
        @(negedge clk);
        cyc++;
        chk("cycle", {29'd0, aud_adclrck, sample_valid, overrun, sample_left, sample_right},
                     {29'd0, (m_run && m_pos == 0), m_valid, m_ovr, m_l, m_r});
        if (track_sync && aud_adclrck) begin
            if (last_sync >= 0) chk("sync_period", 64'(cyc - last_sync), 64'(FL));
            last_sync = cyc;
        end
    endtask

    // One full frame starting at position 0, snapshotting outputs at key points.
    task automatic run_frame(input logic [W-1:0] lw, input logic [W-1:0] rw,
                             input int mode, input int clr_pos);
        nl = lw;
        nr = rw;
        for (int i = 0; i < FL; i++) begin
            int p;
            p = m_pos;
            sample_ready = (mode == 1) || (mode == 2 && p == OFF + 2*W - 1);
            clr_overrun  = (p == clr_pos);
            tick();
            if (m_pos == OFF + 2*W) begin
                s_v33 = sample_valid; s_l33 = sample_left;
                s_r33 = sample_right; s_o33 = overrun;
            end
            if (m_pos == OFF + 2*W + 1) s_v34 = sample_valid;
            if (m_pos == 101) s_o101 = overrun;
        end
        sample_ready = 1'b0;
        clr_overrun  = 1'b0;
    endtask

    initial begin
        tbl[0] = '{16'hA5C3, 16'h1234, 0,  -1, 1'b1, 16'hA5C3, 16'h1234, 1'b0, 1'b1, 1'b0};
        tbl[1] = '{16'h7FFF, 16'h8000, 0, 100, 1'b1, 16'hA5C3, 16'h1234, 1'b1, 1'b1, 1'b0};
        tbl[2] = '{16'h5A5A, 16'h0F0F, 2,  -1, 1'b1, 16'h5A5A, 16'h0F0F, 1'b0, 1'b1, 1'b0};
        tbl[3] = '{16'h1357, 16'h2468, 1,  -1, 1'b1, 16'h1357, 16'h2468, 1'b0, 1'b0, 1'b0};
        tbl[4] = '{16'h8001, 16'h0001, 0,  -1, 1'b1, 16'h8001, 16'h0001, 1'b0, 1'b1, 1'b0};

        reset = 1'b1; enable = 1'b0; sample_ready = 1'b0;
        clr_overrun = 1'b0; aud_adcdat = 1'b0;
        nl = '0; nr = '0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("reset_state", {29'd0, aud_adclrck, sample_valid, overrun, sample_left, sample_right}, 64'd0);
        reset = 1'b0;

        // Idle: no sync while disabled.
        tick();
        tick();
        chk("idle_sync", {63'd0, aud_adclrck}, 64'd0);

        // Enable: sync on the first running cycle, then table of frames.
        enable = 1'b1;
        track_sync = 1'b1;
        tick();
        chk("first_sync", {63'd0, aud_adclrck}, 64'd1);
        for (int i = 0; i < 5; i++) begin
            run_frame(tbl[i].lw, tbl[i].rw, tbl[i].mode, tbl[i].clr_pos);
            chk($sformatf("v33_f%0d", i),  {63'd0, s_v33},  {63'd0, tbl[i].v33});
            chk($sformatf("l33_f%0d", i),  {48'd0, s_l33},  {48'd0, tbl[i].l33});
            chk($sformatf("r33_f%0d", i),  {48'd0, s_r33},  {48'd0, tbl[i].r33});
            chk($sformatf("o33_f%0d", i),  {63'd0, s_o33},  {63'd0, tbl[i].o33});
            chk($sformatf("v34_f%0d", i),  {63'd0, s_v34},  {63'd0, tbl[i].v34});
            chk($sformatf("o101_f%0d", i), {63'd0, s_o101}, {63'd0, tbl[i].o101});
        end
        track_sync = 1'b0;

        // Enable drop at position 20 with a pair still pending.
        nl = 16'hDEAD; nr = 16'hBEEF; sample_ready = 1'b0;
        repeat (20) tick();
        enable = 1'b0;
        tick();
        chk("drop_sync", {63'd0, aud_adclrck}, 64'd0);
        repeat (60) tick();
        chk("drop_hold", {30'd0, aud_adclrck, sample_valid, sample_left, sample_right},
                         {30'd0, 1'b0, 1'b1, 16'h8001, 16'h0001});
        sample_ready = 1'b1;
        tick();
        sample_ready = 1'b0;
        chk("drop_consume", {63'd0, sample_valid}, 64'd0);

        // Re-enable: fresh sync then a clean capture.
        enable = 1'b1;
        tick();
        chk("reen_sync", {63'd0, aud_adclrck}, 64'd1);
        run_frame(16'h00FF, 16'hFF00, 0, -1);
        chk("reen_capture", {31'd0, s_v33, s_l33, s_r33}, {31'd0, 1'b1, 16'h00FF, 16'hFF00});

        // Randomized phase against the model.
        begin
            int rp;
            rp = 0;
            for (int k = 0; k < 3000; k++) begin
                if (m_run && m_pos == 0) begin
                    nl = 16'($urandom);
                    nr = 16'($urandom);
                    rp = $urandom_range(0, 2) * 40;
                end
                sample_ready = ($urandom_range(0, 99) < rp);
                clr_overrun  = ($urandom_range(0, 59) == 0);
                if (enable && $urandom_range(0, 1499) == 0) enable = 1'b0;
                else if (!enable && $urandom_range(0, 7) == 0) enable = 1'b1;
                tick();
            end
        end

        // Reset mid-frame with a pending pair.
        enable = 1'b1; sample_ready = 1'b0; clr_overrun = 1'b0;
        for (int k = 0; k < 300 && !(m_run && m_pos == 0); k++) tick();
        nl = 16'hC001; nr = 16'h0FF0;
        repeat (260) tick();
        chk("pre_reset_valid", {63'd0, sample_valid}, 64'd1);
        #2 reset = 1'b1;
        #1;
        chk("async_reset", {29'd0, aud_adclrck, sample_valid, overrun, sample_left, sample_right}, 64'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        enable = 1'b1;
        tick();
        chk("post_reset_sync", {63'd0, aud_adclrck}, 64'd1);
        nl = 16'h4321; nr = 16'hFEDC;
        run_frame(16'h4321, 16'hFEDC, 1, -1);
        chk("post_reset_capture", {32'd0, s_l33, s_r33}, {32'd0, 16'h4321, 16'hFEDC});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
